// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake and iterative MUL/DIVU/REMU
module alu_seq #(
    parameter int LENGTH = 32,
    parameter int OPW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] A,
    input  logic [LENGTH-1:0] B,
    input  logic [OPW-1:0]    op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] C,
    output logic              z,
    output logic              cout,
    output logic              busy
);
    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [LENGTH-1:0] acc, mcand, mplier, rem, quo, dvsr;
    logic              is_rem;
    logic [LENGTH:0]   sum, dif, rsh, rdif;
    logic [LENGTH-1:0] sc_res, acc_n, rem_n, quo_n;
    logic              sc_cout, ge, last, iter_op;

    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_DONE;
    assign busy      = state == S_MUL || state == S_DIV;
    assign last      = cnt == CW'(LENGTH - 1);
    assign iter_op   = op == OPW'(7) || ((op == OPW'(8) || op == OPW'(9)) && B != '0);

    // single-cycle results; divide by zero resolves here without iterating
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        dif     = {1'b0, A} + {1'b0, ~B} + (LENGTH+1)'(1);
        sc_res  = '0;
        sc_cout = 1'b0;
        case (op)
            OPW'(0): begin sc_res = sum[LENGTH-1:0]; sc_cout = sum[LENGTH]; end
            OPW'(1): sc_res = B;
            OPW'(2): begin sc_res = dif[LENGTH-1:0]; sc_cout = dif[LENGTH]; end
            OPW'(3): sc_res = A & B;
            OPW'(4): sc_res = A | B;
            OPW'(5): sc_res = A ^ B;
            OPW'(6): sc_res = LENGTH'($signed(A) < $signed(B));
            OPW'(8): sc_res = '1;
            OPW'(9): sc_res = A;
            default: sc_res = '0;
        endcase
    end

    // one shift-add step and one restoring-division step
    always_comb begin
        acc_n = acc + (mplier[0] ? mcand : '0);
        rsh   = {rem, quo[LENGTH-1]};
        rdif  = rsh - {1'b0, dvsr};
        ge    = rsh >= {1'b0, dvsr};
        rem_n = ge ? rdif[LENGTH-1:0] : rsh[LENGTH-1:0];
        quo_n = {quo[LENGTH-2:0], ge};
    end

    // handshake FSM, iteration registers and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            is_rem <= 1'b0;
            C      <= '0;
            z      <= 1'b0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    cnt <= '0;
                    if (op == OPW'(7)) begin
                        state  <= S_MUL;
                        acc    <= '0;
                        mcand  <= A;
                        mplier <= B;
                    end else if (iter_op) begin
                        state  <= S_DIV;
                        rem    <= '0;
                        quo    <= A;
                        dvsr   <= B;
                        is_rem <= op == OPW'(9);
                    end else begin
                        state <= S_DONE;
                        C     <= sc_res;
                        z     <= sc_res == '0;
                        cout  <= sc_cout;
                    end
                end
                S_MUL: begin
                    acc    <= acc_n;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state <= S_DONE;
                        C     <= acc_n;
                        z     <= acc_n == '0;
                        cout  <= 1'b0;
                    end
                end
                S_DIV: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= S_DONE;
                        C     <= is_rem ? rem_n : quo_n;
                        z     <= (is_rem ? rem_n : quo_n) == '0;
                        cout  <= 1'b0;
                    end
                end
                default: if (out_ready) state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq handshake, results, latency and reset abort
module tb_alu_seq;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic [3:0]  op = 0;
    logic        in_ready, out_valid, z, cout, busy;
    logic [31:0] c;
    int total = 0, bad = 0;

    alu_seq #(.LENGTH(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .C(c), .z(z), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          output int lat, output int bc);
        in_valid = 1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        in_valid = 0; a = $urandom; b = $urandom; op = 4'($urandom);
        lat = 1; bc = int'(busy);
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            bc += int'(busy);
        end
    endtask

    task automatic take();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if ({out_valid, busy, z, cout} !== 4'b0 || c !== 32'h0) begin bad++;
            $display("FAIL reset_held got ov=%b busy=%b z=%b cout=%b C=%h exp all 0", out_valid, busy, z, cout, c); end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 32'h0) begin bad++;
            $display("FAIL reset_release got in_ready=%b ov=%b C=%h exp 1 0 0", in_ready, out_valid, c); end
    endtask

    task automatic test_single();
        logic [3:0]  to [16] = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 6, 6, 12, 8, 9, 0, 9};
        logic [31:0] ta [16] = '{32'hFFFFFFFF, 32'hDEADBEEF, 5, 7, 5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'hFFFFFFFF, 1, 32'h80000000, 5, 123, 9, 32'h7FFFFFFF, 0};
        logic [31:0] tb [16] = '{1, 32'h12345000, 7, 5, 5, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                                 1, 32'hFFFFFFFF, 32'h7FFFFFFF, 6, 0, 0, 1, 0};
        logic [31:0] te [16] = '{0, 32'h12345000, 32'hFFFFFFFE, 2, 0, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                                 1, 0, 1, 0, 32'hFFFFFFFF, 9, 32'h80000000, 0};
        logic        tc [16] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int lat, bc;
        for (int i = 0; i < 16; i++) begin
            run_op(to[i], ta[i], tb[i], lat, bc);
            total++; if (lat !== 1) begin bad++; $display("FAIL single%0d_latency got %0d exp 1", i, lat); end
            total++; if (c !== te[i]) begin bad++; $display("FAIL single%0d_C got %h exp %h", i, c, te[i]); end
            total++; if (z !== (te[i] == 0)) begin bad++; $display("FAIL single%0d_z got %b exp %b", i, z, te[i] == 0); end
            total++; if (cout !== tc[i]) begin bad++; $display("FAIL single%0d_cout got %b exp %b", i, cout, tc[i]); end
            take();
        end
    endtask

    task automatic test_iter();
        logic [3:0]  to [8] = '{7, 7, 7, 8, 9, 8, 9, 8};
        logic [31:0] ta [8] = '{7, 32'h00010000, 32'hFFFFFFFF, 100, 100, 32'hFFFFFFFF, 5, 32'h80000000};
        logic [31:0] tb [8] = '{6, 32'h00010000, 32'hFFFFFFFF, 7, 7, 1, 9, 3};
        logic [31:0] te [8] = '{42, 0, 1, 14, 2, 32'hFFFFFFFF, 5, 32'h2AAAAAAA};
        int lat, bc;
        for (int i = 0; i < 8; i++) begin
            run_op(to[i], ta[i], tb[i], lat, bc);
            total++; if (lat !== 33) begin bad++; $display("FAIL iter%0d_latency got %0d exp 33", i, lat); end
            total++; if (bc !== 32) begin bad++; $display("FAIL iter%0d_busy_cycles got %0d exp 32", i, bc); end
            total++; if (c !== te[i]) begin bad++; $display("FAIL iter%0d_C got %h exp %h", i, c, te[i]); end
            total++; if (z !== (te[i] == 0) || cout !== 1'b0) begin bad++;
                $display("FAIL iter%0d_flags got z=%b cout=%b exp z=%b cout=0", i, z, cout, te[i] == 0); end
            take();
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(0, 2, 3, lat, bc);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; op = 0; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            total++; if (c !== 32'd5 || in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++;
                $display("FAIL hold%0d got C=%h in_ready=%b ov=%b exp 5 0 1", i, c, in_ready, out_valid); end
        end
        a = 10; b = 20; op = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++;
            $display("FAIL release got in_ready=%b ov=%b exp 1 0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || c !== 32'd30) begin bad++;
            $display("FAIL second_accept got ov=%b C=%h exp 1 0000001e", out_valid, c); end
        take();
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        in_valid = 1; op = 7; a = 7; b = 6;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy got %b exp 1", busy); end
        rst_n = 0; #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || c !== 32'h0 || z !== 1'b0) begin bad++;
            $display("FAIL abort got ov=%b busy=%b C=%h z=%b exp 0 0 0 0", out_valid, busy, c, z); end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        run_op(0, 2, 3, lat, bc);
        total++; if (lat !== 1 || c !== 32'd5 || cout !== 1'b0) begin bad++;
            $display("FAIL post_abort got lat=%0d C=%h cout=%b exp 1 5 0", lat, c, cout); end
        take();
    endtask

    initial begin
        test_reset();
        test_single();
        test_iter();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
